qpsk_demod_ctrl: RTL
====================

// Module: qpsk_demod_ctrl
// PURPOSE
// - Sequences QPSK_demod: decimates the I/Q sample stream to one symbol per SPS clocks and drives the demod's I/Q inputs.
// - Collects the returned dibits, hunts for a sync byte and packs each frame's payload into bytes.
// - Delivers payload bytes on a valid/ready interface. Sits between the sample front end and the byte sink.
// PARAMETERS
// - SPS          8      samples per symbol (>=2); symbol period in CLOCK_256 cycles
// - SAMPLE_PHASE 3      counter value (0..SPS-1) at which I_in/Q_in are captured
// - DEMOD_LAT    1      clocks from I/Q capture to a valid demod_bits
// - SYNC_WORD    8'hA5  frame sync byte, MSB dibit first
// - FRAME_BYTES  4      payload bytes per frame after sync (>=1)
// PORTS
// - CLOCK_256   in   1  system clock
// - reset       in   1  synchronous, active-low reset
// - enable      in   1  run control; low forces IDLE
// - I_in, Q_in  in   2  raw I/Q samples, 2's complement
// - I, Q        out  2  registered symbol to QPSK_demod
// - demod_bits  in   4  QPSK_demod output; only [1:0] (dibit) is used
// - sym_strobe  out  1  1-cycle pulse in the cycle I/Q are updated
// - out_data    out  8  payload byte
// - out_valid   out  1  out_data valid; held until accepted
// - out_ready   in   1  sink accepts when out_valid && out_ready
// - locked      out  1  high while in LOCKED
// - overflow    out  1  sticky: a payload byte was dropped
// BEHAVIOUR
// - Reset (reset==0 at a clock edge): I=Q=0, sym_strobe=0, out_data=0, out_valid=0, locked=0, overflow=0.
//   Counters, shift register and delay line cleared; state=IDLE. Reset mid-frame discards the partial byte.
// - States: IDLE -> HUNT when enable=1. HUNT -> LOCKED on sync match. LOCKED -> HUNT after FRAME_BYTES bytes.
//   Any state -> IDLE when enable=0.
// - IDLE: sym_cnt held at 0, out_valid forced 0, overflow cleared, I/Q held.
// - Sym counter: sym_cnt counts 0..SPS-1 and wraps in HUNT/LOCKED.
//   - When sym_cnt==SAMPLE_PHASE: I<=I_in, Q<=Q_in; sym_strobe=1 in the following cycle (aligned with new I/Q).
// - Dibit valid: sym_strobe delayed by DEMOD_LAT cycles; demod_bits[1:0] is sampled only on dibit_valid.
// - HUNT: on each dibit_valid, win <= {win[5:0], dibit}.
//   - A match (the updated win == SYNC_WORD) moves to LOCKED next cycle.
//   - On the match: dibit_cnt=0 and byte_cnt=0; win is cleared.
// - LOCKED: each dibit_valid shifts the dibit into pack[7:0], MSB first; dibit_cnt 0..3.
//   - On the 4th dibit, the byte is complete: {pack[5:0], dibit} is offered next edge and byte_cnt increments.
//   - When byte_cnt reaches FRAME_BYTES-1 and the byte completes: state -> HUNT at the same edge.
// - Output rules at byte completion (latency: out_valid rises 1 clock after the 4th dibit_valid):
//   - If !out_valid, or out_valid && out_ready in the same cycle: load out_data and set out_valid=1.
//     Simultaneous accept+reload is legal and is not an overflow.
//   - If out_valid && !out_ready: the new byte is dropped, overflow<=1 and out_data is unchanged.
//   - Otherwise, out_valid && out_ready clears out_valid.
//   - out_data is stable while out_valid && !out_ready.
// - enable 1->0 mid-frame: next cycle IDLE, locked=0, out_valid=0, and in-flight dibits in the delay line are discarded.
// - Width rules: sym_cnt is $clog2(SPS) bits; byte_cnt is $clog2(FRAME_BYTES+1) bits.
//   No arithmetic is done on I/Q; they pass through unchanged.
// STRUCTURE
// - qpsk_pkg:
//   - typedef enum logic [1:0] {IDLE, HUNT, LOCKED} qpsk_state_t
//   - typedef logic [1:0] dibit_t
//   - localparam DEFAULT_SYNC = 8'hA5
//   - constellation constants for the four symbols:
//     - 00: I=01, Q=00
//     - 01: I=00, Q=01
//     - 11: I=11, Q=00
//     - 10: I=00, Q=11
// - Sub-module qpsk_byte_packer: dibit shift, dibit_cnt and the valid/ready output register with overflow.
//   The top level holds the FSM, sym_cnt, capture and the delay line.
// TESTING (directed; QPSK_demod instantiated, SPS=4, SAMPLE_PHASE=1, FRAME_BYTES=2)
// - Reset: hold reset=0 for 3 clocks with random I_in/Q_in -> all outputs 0, state IDLE; no sym_strobe for 20 clocks with enable=0.
// - Strobe timing: enable=1 -> sym_strobe every 4 clocks; I/Q equal I_in/Q_in sampled at sym_cnt==1.
// - Sync + payload: send dibits 10,10,01,01 (A5), then bytes 8'h1B and 8'hE4 with out_ready=1.
//   -> locked rises after the 4th sync dibit; out_valid pulses with 1B then E4.
//   -> locked falls after E4; no overflow.
// - False sync: send 8'hA4 and then noise -> locked stays 0 and out_valid never asserts.
// - Backpressure: out_ready=0 through both payload bytes -> out_data=1B held, overflow=1.
//   Then out_ready=1 -> 1B accepted, out_valid=0.
// - Abort: enable=0 after 2 payload dibits -> next cycle IDLE, locked=0, out_valid=0.
//   Re-enable and a new sync -> clean frame, with its first byte correct.

Source files
------------

// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared types and constellation constants for the QPSK demod controller
package qpsk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } qpsk_state_t;

    typedef logic [1:0] dibit_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    // Constellation point per dibit, indexed by the dibit value.
    // 00: I=01 Q=00, 01: I=00 Q=01, 10: I=00 Q=11, 11: I=11 Q=00
    localparam logic [3:0][1:0] SYM_I = {2'b11, 2'b00, 2'b00, 2'b01};
    localparam logic [3:0][1:0] SYM_Q = {2'b00, 2'b11, 2'b01, 2'b00};

endpackage

// File: rtl/qpsk_byte_packer.sv
// rtl/qpsk_byte_packer.sv - packs dibits into bytes and holds the valid/ready output register
module qpsk_byte_packer
    import qpsk_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_flush,
    input  logic       i_idle,
    input  logic       i_shift,
    input  dibit_t     i_dibit,
    input  logic       i_out_ready,
    output logic       o_byte_done,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_overflow
);

    // Only the three oldest dibits need storing; the fourth arrives with the completion.
    logic [5:0] r_pack;
    logic [1:0] r_dibit_cnt;
    logic [7:0] w_byte;

    assign o_byte_done = i_shift && (r_dibit_cnt == 2'd3);
    assign w_byte      = {r_pack, i_dibit};

    // Dibit shift register and position counter; a flush discards any partial byte.
    always_ff @(posedge clk) begin
        if (!resetn || i_flush) begin
            r_pack      <= '0;
            r_dibit_cnt <= '0;
        end else if (i_shift) begin
            r_pack      <= {r_pack[3:0], i_dibit};
            r_dibit_cnt <= r_dibit_cnt + 2'd1;
        end
    end

    // Output register: load when empty or being drained this cycle, otherwise drop and flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_idle) begin
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (o_byte_done) begin
            if (!o_valid || i_out_ready) begin
                o_data  <= w_byte;
                o_valid <= 1'b1;
            end else begin
                o_overflow <= 1'b1;
            end
        end else if (o_valid && i_out_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qpsk_demod_ctrl.sv
// rtl/qpsk_demod_ctrl.sv - symbol decimation, sync hunt and frame sequencing around QPSK_demod
module qpsk_demod_ctrl
    import qpsk_pkg::*;
#(
    parameter int         SPS          = 8,
    parameter int         SAMPLE_PHASE = 3,
    parameter int         DEMOD_LAT    = 1,
    parameter logic [7:0] SYNC_WORD    = DEFAULT_SYNC,
    parameter int         FRAME_BYTES  = 4
) (
    input  logic       CLOCK_256,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] I_in,
    input  logic [1:0] Q_in,
    output logic [1:0] I,
    output logic [1:0] Q,
    input  logic [3:0] demod_bits,
    output logic       sym_strobe,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       locked,
    output logic       overflow
);

    localparam int            CW        = $clog2(SPS);
    localparam int            BW        = $clog2(FRAME_BYTES + 1);
    localparam logic [CW-1:0] SYM_LAST  = CW'(SPS - 1);
    localparam logic [CW-1:0] PHASE     = CW'(SAMPLE_PHASE);
    localparam logic [BW-1:0] BYTE_LAST = BW'(FRAME_BYTES - 1);

    qpsk_state_t          r_state;
    logic [CW-1:0]        r_sym_cnt;
    logic [DEMOD_LAT-1:0] r_dly;
    logic [5:0]           r_win;
    logic [BW-1:0]        r_byte_cnt;

    logic       w_dibit_valid;
    dibit_t     w_dibit;
    logic [7:0] w_win_next;
    logic       w_match;
    logic       w_shift;
    logic       w_flush;
    logic       w_idle;
    logic       w_byte_done;
    logic       w_unused_bits;

    assign w_dibit_valid = r_dly[DEMOD_LAT-1];
    assign w_dibit       = demod_bits[1:0];
    assign w_unused_bits = ^demod_bits[3:2];
    assign w_win_next    = {r_win, w_dibit};
    assign w_match       = (r_state == HUNT) && w_dibit_valid && (w_win_next == SYNC_WORD);
    assign w_shift       = enable && (r_state == LOCKED) && w_dibit_valid;
    assign w_idle        = !enable || (r_state == IDLE);
    assign w_flush       = w_idle || w_match;

    qpsk_byte_packer u_packer (
        .clk         (CLOCK_256),
        .resetn      (reset),
        .i_flush     (w_flush),
        .i_idle      (w_idle),
        .i_shift     (w_shift),
        .i_dibit     (w_dibit),
        .i_out_ready (out_ready),
        .o_byte_done (w_byte_done),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_overflow  (overflow)
    );

    // Control FSM with symbol counter, I/Q capture and the demod latency delay line.
    always_ff @(posedge CLOCK_256) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_sym_cnt  <= '0;
            r_dly      <= '0;
            r_win      <= '0;
            r_byte_cnt <= '0;
            I          <= '0;
            Q          <= '0;
            sym_strobe <= 1'b0;
            locked     <= 1'b0;
        end else if (!enable) begin
            // I/Q deliberately held; everything in flight is dropped.
            r_state    <= IDLE;
            r_sym_cnt  <= '0;
            r_dly      <= '0;
            r_win      <= '0;
            r_byte_cnt <= '0;
            sym_strobe <= 1'b0;
            locked     <= 1'b0;
        end else if (r_state == IDLE) begin
            r_state    <= HUNT;
            r_sym_cnt  <= '0;
            r_dly      <= '0;
            sym_strobe <= 1'b0;
        end else begin
            r_sym_cnt  <= (r_sym_cnt == SYM_LAST) ? '0 : r_sym_cnt + CW'(1);
            sym_strobe <= (r_sym_cnt == PHASE);
            if (r_sym_cnt == PHASE) begin
                I <= I_in;
                Q <= Q_in;
            end
            r_dly[0] <= sym_strobe;
            for (int k = 1; k < DEMOD_LAT; k++) begin
                r_dly[k] <= r_dly[k-1];
            end

            if (r_state == HUNT) begin
                if (w_dibit_valid) begin
                    if (w_match) begin
                        r_state    <= LOCKED;
                        locked     <= 1'b1;
                        r_win      <= '0;
                        r_byte_cnt <= '0;
                    end else begin
                        r_win <= w_win_next[5:0];
                    end
                end
            end else if (w_byte_done) begin
                if (r_byte_cnt == BYTE_LAST) begin
                    r_state    <= HUNT;
                    locked     <= 1'b0;
                    r_byte_cnt <= '0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + BW'(1);
                end
            end
        end
    end

endmodule
